lc3_mem_arbiter: RTL and testbench
==================================

# lc3_mem_arbiter

Two-port arbiter and sequencer in front of the LC-3 main-memory block (BRAM wrapper with `re`/`we` strobes, 7-bit read/write addresses, 16-bit data and a `ready_bit` handshake). It shares the single memory between the CPU memory path (MAR/MDR) on port 0 and the debug/program-loader on port 1. It converts each requester's req/ack handshake into a correctly held memory strobe and returns read data. It bounds every access with a timeout so a missing `ready_bit` cannot hang the CPU.

## Interface

Parameters:
- `AW`, 7: memory address width, matching the MAR-curtailed address.
- `DW`, 16: data width.
- `TIMEOUT`, 15: maximum ACCESS cycles without `mem_ready` before the access is aborted. Must be ≥ 3.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `p0_req`, `p1_req`  in  1  access request. Held high with stable addr/we/wdata until ack.
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read.
- `p0_addr`, `p1_addr`  in  AW  word address.
- `p0_wdata`, `p1_wdata`  in  DW  write data.
- `p0_ack`, `p1_ack`  out  1  one-cycle completion pulse.
- `p0_err`, `p1_err`  out  1  qualifies ack: 1 = timed out.
- `rdata`  out  DW  read data (shared), valid in the ack cycle.
- `mem_re`, `mem_we`  out  1  memory strobes, never both high.
- `mem_raddr`, `mem_waddr`  out  AW  both driven with the granted address.
- `mem_d`  out  DW  write data to memory.
- `mem_dout`  in  DW  memory read data.
- `mem_ready`  in  1  memory `ready_bit`.

## Operation

- FSM states: IDLE, ACCESS, RECOVER. All outputs are registered.
- **IDLE:**
  - If any req is pending, grant one port and latch its we/addr/wdata, then go to ACCESS.
  - If only one port requests, that port is granted.
  - If both request, grant round-robin: the port not granted last wins. The `last` pointer resets to 1, so port 0 wins the first tie.
- **ACCESS:**
  - Drive `mem_we`=latched we or `mem_re`=!we, with addresses/data from the latch, held constant.
  - A timeout counter increments each ACCESS cycle.
  - If `mem_ready`=1: capture `rdata` <= `mem_dout` (reads only; `rdata` holds its value on writes), pulse the granted port's ack with err=0, drop strobes, go to RECOVER.
  - Else if counter = TIMEOUT−1: drop strobes, pulse ack with err=1, leave `rdata` unchanged, go to RECOVER.
- **RECOVER:**
  - Strobes stay low.
  - Wait until `mem_ready`=0 is sampled, then go to IDLE. This clears the memory's stale ready and delayed-ready state.
  - Stays at least 1 cycle. It has no timeout: a stuck-high `mem_ready` holds the arbiter here.
- The update of the `last` pointer to the granted port happens on grant.
- A req still high in the ack cycle is not a new request. It is resampled in IDLE, so a held req produces back-to-back transactions.
- **Reset:**
  - Values: state=IDLE, all acks/errs=0, `mem_re`=`mem_we`=0, addresses/`mem_d`/`rdata`=0, counter=0, `last`=1.
  - A reset asserted mid-ACCESS aborts the access without an ack. Strobes are low the cycle after the reset edge.

## Timing

- The cycle numbering below assumes the memory block's behaviour: a write gives `mem_ready` 1 cycle after the first `we` cycle; a read gives it 2 cycles after the first `re` cycle.
- Cycle counting uses req sampled high in IDLE at cycle N.
- Grant edge ends cycle N, so strobes are high from N+1.
- Write: strobes N+1..N+2, ack at N+3.
- Read: strobes N+1..N+3, ack at N+4, `rdata` valid at N+4 and held until the next read ack.
- RECOVER lasts until `mem_ready` is low, typically exiting at N+5 (write) or N+6 (read). The next grant is no earlier than the cycle after returning to IDLE.
- Timeout: ack with err=1 exactly TIMEOUT cycles after the first strobe cycle.
- Ack is exactly one cycle wide. `p0_ack` and `p1_ack` are never high together.

## Test plan

- Reset, then p0 writes addr 7'h05 data 16'hBEEF: `mem_we` high exactly 2 cycles at addr 05, `p0_ack` pulses 3 cycles after req, `p0_err`=0, `mem_re` never high.
- p0 reads 7'h05 after that write: `mem_re` held 3 cycles, `p0_ack` 4 cycles after req with `rdata`=16'hBEEF. p1 stays silent.
- p0 and p1 both request in the same cycle, held high (p0 reads 7'h01, p1 writes 7'h02 = 16'h1234): grants alternate p0, p1, p0, p1. No overlapping strobes, no double acks.
- Memory model with `mem_ready` tied 0, TIMEOUT=15, p1 read: `p1_ack` with `p1_err`=1 exactly 15 cycles after the first `mem_re` cycle, `rdata` unchanged. The next request is serviced normally once `mem_ready`=0.
- `rst` asserted in the second cycle of a p0 read: no `p0_ack`, strobes low the next cycle, all outputs at reset values, and a fresh p0 read completes correctly.
- `mem_ready` forced high after an ack: the arbiter stays in RECOVER and ignores p0/p1 requests; releasing `mem_ready` returns it to IDLE and services the pending request.

Source files
------------

// File: rtl/lc3_mem_arbiter_if.sv
// Request/ack bundle for both ports plus the BRAM strobe/data bus.
// slave: arbiter view; master: requesters-and-memory view.
interface lc3_mem_arbiter_if #(
  parameter int AW = 7,
  parameter int DW = 16
);
  logic          p0_req;
  logic          p1_req;
  logic          p0_we;
  logic          p1_we;
  logic [AW-1:0] p0_addr;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p0_wdata;
  logic [DW-1:0] p1_wdata;
  logic          p0_ack;
  logic          p1_ack;
  logic          p0_err;
  logic          p1_err;
  logic [DW-1:0] rdata;
  logic          mem_re;
  logic          mem_we;
  logic [AW-1:0] mem_raddr;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_d;
  logic [DW-1:0] mem_dout;
  logic          mem_ready;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we,
    input  p0_addr, p1_addr, p0_wdata, p1_wdata,
    output p0_ack, p1_ack, p0_err, p1_err, rdata,
    output mem_re, mem_we, mem_raddr, mem_waddr, mem_d,
    input  mem_dout, mem_ready
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we,
    output p0_addr, p1_addr, p0_wdata, p1_wdata,
    input  p0_ack, p1_ack, p0_err, p1_err, rdata,
    input  mem_re, mem_we, mem_raddr, mem_waddr, mem_d,
    output mem_dout, mem_ready
  );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for LC-3 main memory with timeout.
// Ports: clk, rst (sync, active-high), bus (lc3_mem_arbiter_if.slave).
module lc3_mem_arbiter #(
  parameter int AW      = 7,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst,
  lc3_mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          sel_q, sel_d;
  logic          lwe_q, lwe_d;
  logic          re_q, re_d;
  logic          we_q, we_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          err0_q, err0_d;
  logic          err1_q, err1_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wd_q, wd_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    lwe_d   = lwe_q;
    re_d    = re_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    err0_d  = 1'b0;
    err1_d  = 1'b0;
    gnt     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // p1 wins when alone, or on a tie when p0 was granted last
        gnt = bus.p1_req & (~bus.p0_req | ~last_q);
        if (bus.p0_req | bus.p1_req) begin
          sel_d   = gnt;
          last_d  = gnt;
          lwe_d   = gnt ? bus.p1_we : bus.p0_we;
          addr_d  = gnt ? bus.p1_addr : bus.p0_addr;
          wd_d    = gnt ? bus.p1_wdata : bus.p0_wdata;
          we_d    = lwe_d;
          re_d    = ~lwe_d;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        if (bus.mem_ready) begin
          if (!lwe_q) rdata_d = bus.mem_dout;
          ack0_d  = ~sel_q;
          ack1_d  = sel_q;
          re_d    = 1'b0;
          we_d    = 1'b0;
          state_d = RECOVER;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          ack0_d  = ~sel_q;
          ack1_d  = sel_q;
          err0_d  = ~sel_q;
          err1_d  = sel_q;
          re_d    = 1'b0;
          we_d    = 1'b0;
          state_d = RECOVER;
        end
      end
      RECOVER: begin
        // flush stale/delayed ready before the next grant
        if (!bus.mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      lwe_q   <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      lwe_q   <= lwe_d;
      re_q    <= re_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
    end
  end

  assign bus.p0_ack    = ack0_q;
  assign bus.p1_ack    = ack1_q;
  assign bus.p0_err    = err0_q;
  assign bus.p1_err    = err1_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_re    = re_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_raddr = addr_q;
  assign bus.mem_waddr = addr_q;
  assign bus.mem_d     = wd_q;
endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Bench for lc3_mem_arbiter: BRAM-like memory model plus reference checks.
// Drives both ports through the interface; prints one summary line.
module tb_lc3_mem_arbiter;
  localparam int AW = 7;
  localparam int DW = 16;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lc3_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  lc3_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // memory block model: write ready 1 cycle, read ready 2 cycles
  logic [DW-1:0] mem_arr [0:127];
  logic          rdy_m;
  logic [DW-1:0] dout_m;
  int            wc;
  int            rc;
  logic          tie0;
  logic          stuck;

  assign bus.mem_ready = stuck ? 1'b1 : (tie0 ? 1'b0 : rdy_m);
  assign bus.mem_dout  = dout_m;

  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem_arr[bus.mem_waddr] <= bus.mem_d;
      wc    <= wc + 1;
      rdy_m <= 1'b1;
    end else if (bus.mem_re) begin
      rc    <= rc + 1;
      rdy_m <= (rc >= 1);
      if (rc >= 1) dout_m <= mem_arr[bus.mem_raddr];
    end else begin
      wc    <= 0;
      rc    <= 0;
      rdy_m <= 1'b0;
    end
  end

  // reference state
  logic [DW-1:0] ref_mem [0:127];
  logic [DW-1:0] exp_rdata;
  logic          model_last;
  int            errors = 0;
  int            checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int p, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = d; bus.p0_req = 1'b1;
    end else begin
      bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = d; bus.p1_req = 1'b1;
    end
  endtask

  task automatic drop(input int p);
    if (p == 0) bus.p0_req = 1'b0;
    else bus.p1_req = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".acks"}, {bus.p0_ack, bus.p1_ack, bus.p0_err, bus.p1_err}, 0);
    chk({tag, ".strb"}, {bus.mem_re, bus.mem_we}, 0);
    chk({tag, ".addr"}, {bus.mem_raddr, bus.mem_waddr}, 0);
    chk({tag, ".mem_d"}, bus.mem_d, 0);
    chk({tag, ".rdata"}, bus.rdata, 0);
  endtask

  task automatic do_reset();
    bus.p0_req = 1'b0;
    bus.p1_req = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;
    exp_rdata  = '0;
    model_last = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_ack(input int p, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int exp_lat, input logic exp_err,
                          input string tag);
    int lat = 0;
    int nre = 0;
    int nwe = 0;
    int bad = 0;
    int ne;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.mem_re && bus.mem_we) bad++;
      if (bus.mem_re || bus.mem_we) begin
        nre += int'(bus.mem_re);
        nwe += int'(bus.mem_we);
        if (bus.mem_raddr !== a || bus.mem_waddr !== a) bad++;
        if (bus.mem_we && bus.mem_d !== d) bad++;
      end
      if ((p == 0 ? bus.p1_ack : bus.p0_ack) !== 1'b0) bad++;
      if ((p == 0 ? bus.p0_ack : bus.p1_ack) === 1'b1) lat = k;
    end
    chk({tag, ".lat"}, lat, exp_lat);
    if (lat != 0) begin
      chk({tag, ".err"}, (p == 0) ? bus.p0_err : bus.p1_err, exp_err);
      if (!exp_err) begin
        if (we) ref_mem[a] = d;
        else exp_rdata = ref_mem[a];
      end
      chk({tag, ".rdata"}, bus.rdata, exp_rdata);
    end
    ne = exp_err ? TO : (we ? 2 : 3);
    chk({tag, ".nwe"}, nwe, we ? ne : 0);
    chk({tag, ".nre"}, nre, we ? 0 : ne);
    chk({tag, ".bus"}, bad, 0);
    drop(p);
    model_last = (p == 1);
    @(negedge clk);
    chk({tag, ".ackw"}, {bus.p0_ack, bus.p1_ack}, 0);
  endtask

  task automatic txn(input int p, input logic we,
                     input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input string tag);
    issue(p, we, a, d);
    wait_ack(p, we, a, d, we ? 3 : 4, 1'b0, tag);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int p;
    int bad;
    int got;
    int lat;
    logic win;
    logic [DW-1:0] d;
    logic [AW-1:0] a;

    rst = 1'b1;
    tie0 = 1'b0;
    stuck = 1'b0;
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    bus.p0_we = 1'b0; bus.p1_we = 1'b0;
    bus.p0_addr = '0; bus.p1_addr = '0;
    bus.p0_wdata = '0; bus.p1_wdata = '0;
    exp_rdata = '0;
    model_last = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset("por");
    rst = 1'b0;
    @(negedge clk);

    txn(0, 1'b1, 7'h05, 16'hBEEF, "wr05");
    txn(0, 1'b0, 7'h05, '0, "rd05");

    for (int i = 0; i < 8; i++) begin
      p = int'($urandom_range(0, 1));
      d = DW'($urandom);
      txn(p, 1'b1, AW'(8 + i), d, "rndwr");
    end
    for (int i = 0; i < 8; i++) begin
      p = int'($urandom_range(0, 1));
      a = AW'(8 + $urandom_range(0, 7));
      txn(p, 1'b0, a, '0, "rndrd");
    end
    txn(1, 1'b1, 7'h01, DW'($urandom), "wr01");

    // timeout with ready tied low
    tie0 = 1'b1;
    issue(1, 1'b0, 7'h03, '0);
    wait_ack(1, 1'b0, 7'h03, '0, TO + 1, 1'b1, "tmo");
    tie0 = 1'b0;
    repeat (2) @(negedge clk);
    txn(0, 1'b1, 7'h06, 16'h5A5A, "post_tmo_wr");
    txn(1, 1'b0, 7'h06, '0, "post_tmo_rd");

    // reset in the second strobe cycle of a read
    issue(0, 1'b0, 7'h05, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drop(0);
    @(negedge clk);
    rst = 1'b0;
    exp_rdata  = '0;
    model_last = 1'b1;
    chk_reset("rst_mid");
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.p0_ack !== 1'b0 || bus.mem_re !== 1'b0) bad++;
    end
    chk("rst_mid.quiet", bad, 0);
    txn(0, 1'b0, 7'h05, '0, "rd_after_rst");

    // tie with both requests held: alternate from p0
    do_reset();
    issue(0, 1'b0, 7'h01, '0);
    issue(1, 1'b1, 7'h02, 16'h1234);
    lat = 0;
    for (int n = 0; n < 4; n++) begin
      win = ~model_last;
      got = -1;
      bad = 0;
      for (int k = 1; k <= 30 && got < 0; k++) begin
        @(negedge clk);
        lat++;
        if (bus.mem_re && bus.mem_we) bad++;
        if (bus.p0_ack && bus.p1_ack) bad++;
        if (bus.p0_ack === 1'b1) got = 0;
        else if (bus.p1_ack === 1'b1) got = 1;
      end
      if (n == 0) chk("tie.lat0", lat, 4);
      chk("tie.order", got, int'(win));
      chk("tie.bus", bad, 0);
      chk("tie.err", {bus.p0_err, bus.p1_err}, 0);
      model_last = win;
      if (!win) begin
        exp_rdata = ref_mem[1];
        chk("tie.rdata", bus.rdata, exp_rdata);
      end else begin
        ref_mem[2] = 16'h1234;
      end
    end
    drop(0);
    drop(1);
    repeat (3) @(negedge clk);
    txn(0, 1'b0, 7'h02, '0, "rd02");

    // ready stuck high holds the arbiter in recovery
    issue(0, 1'b1, 7'h09, 16'hC3C3);
    wait_ack(0, 1'b1, 7'h09, 16'hC3C3, 3, 1'b0, "stk_wr");
    stuck = 1'b1;
    issue(1, 1'b0, 7'h09, '0);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.mem_re || bus.mem_we || bus.p0_ack || bus.p1_ack) bad++;
    end
    chk("stuck.hold", bad, 0);
    stuck = 1'b0;
    wait_ack(1, 1'b0, 7'h09, '0, 5, 1'b0, "stk_rel");
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
